if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC,

---
 rtl/if_pkg.sv | 15 +
 rtl/if_prefetch_fifo.sv | 71 +++++++
 rtl/if_fetch_unit.sv | 109 ++++++++++
 tb/tb_if_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and FSM state type for the instruction-fetch stage
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;
  // Wide enough to count up to the largest legal FIFO depth (4)
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_prefetch_fifo.sv
// rtl/if_prefetch_fifo.sv - show-ahead circular prefetch buffer; flush beats push and pop
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [2**PTR_W];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !do_pop) count_d = count_q + CNT_W'(1);
      else if (!push_i && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
      if (!rst_i && !do_pop) assert (count_q != FULL_CNT);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC owner, req/ack fetch FSM, redirect handling and IF/ID presentation
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Hazard_stall_i,
  input  logic        brench_i,
  input  logic [31:0] brench_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] addedPC_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  localparam logic [CNT_W:0] DEPTH_CNT = FIFO_DEPTH[CNT_W:0];

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d, addr_q, addr_d;
  logic [31:0]      target_raw, target, pc_plus4;
  logic [CNT_W-1:0] fifo_count;
  logic [63:0]      fifo_head;
  logic [CNT_W:0]   occupancy;
  logic             fifo_push, fifo_pop, redirect, outstanding, room;

  assign redirect    = brench_i | jump_i;
  assign target_raw  = brench_i ? brench_target_i : jump_target_i;
  assign target      = {target_raw[31:2], 2'b00};
  assign pc_plus4    = pc_q + PC_INC;
  assign outstanding = (state_q != IDLE);
  assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding};
  assign room        = occupancy < DEPTH_CNT;

  // Request is combinational so an IDLE cycle with room issues immediately
  assign imem_req_o  = ~rst_i & (outstanding | room);
  assign imem_addr_o = !imem_req_o ? 32'h0 : (outstanding ? addr_q : pc_q);

  assign valid_o   = (fifo_count != '0);
  assign fifo_pop  = valid_o & ~Hazard_stall_i;
  assign addedPC_o = valid_o ? fifo_head[63:32] : 32'h0;
  assign inst_o    = valid_o ? fifo_head[31:0] : NOP_INST;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        // A request issued alongside a redirect is already stale, so wait it out in DROP
        if (room) begin
          addr_d  = pc_q;
          state_d = redirect ? DROP : REQ;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          state_d = IDLE;
          if (!redirect) begin
            fifo_push = 1'b1;
            pc_d      = pc_plus4;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) pc_d = target;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  if_prefetch_fifo #(
    .WIDTH(64),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_data_i({pc_plus4, imem_rdata_i}),
    .pop_i      (fifo_pop),
    .flush_i    (redirect),
    .count_o    (fifo_count),
    .head_o     (fifo_head)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with variable-latency memory models
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, rst2_i;
  logic        stall_i, brench_i, jump_i;
  logic [31:0] brench_target_i, jump_target_i;

  logic        req, ack, valid;
  logic [31:0] addr, rdata, added_pc, inst;
  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, added_pc2, inst2;

  int mem_lat;
  int mem_cnt, mem2_cnt;
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  always #5 clk_i = ~clk_i;

  assign ack   = req && (mem_cnt >= mem_lat);
  assign rdata = inst_of(addr);
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem_cnt <= 0;
    else if (ack) mem_cnt <= 0;
    else if (req) mem_cnt <= mem_cnt + 1;
  end

  assign ack2   = req2 && (mem2_cnt >= 1);
  assign rdata2 = inst_of(addr2);
  always @(posedge clk_i or posedge rst2_i) begin
    if (rst2_i) mem2_cnt <= 0;
    else if (ack2) mem2_cnt <= 0;
    else if (req2) mem2_cnt <= mem2_cnt + 1;
  end

  if_fetch_unit u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Hazard_stall_i (stall_i),
    .brench_i       (brench_i),
    .brench_target_i(brench_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_ack_i     (ack),
    .imem_rdata_i   (rdata),
    .addedPC_o      (added_pc),
    .inst_o         (inst),
    .valid_o        (valid)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_hi (
    .clk_i          (clk_i),
    .rst_i          (rst2_i),
    .Hazard_stall_i (stall_i),
    .brench_i       (brench_i),
    .brench_target_i(brench_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .imem_req_o     (req2),
    .imem_addr_o    (addr2),
    .imem_ack_i     (ack2),
    .imem_rdata_i   (rdata2),
    .addedPC_o      (added_pc2),
    .inst_o         (inst2),
    .valid_o        (valid2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; rst2_i = 1'b1;
    stall_i = 1'b0; brench_i = 1'b0; jump_i = 1'b0;
    brench_target_i = 32'h0; jump_target_i = 32'h0;
    mem_lat = 1;

    // reset state, then 1-cycle memory streaming
    nxt();
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_added", added_pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_valid", valid, 0);
    chk("rst_req_hi", req2, 0);
    rst_i = 1'b0;
    #1;
    chk("first_req", req, 1);
    chk("first_addr", addr, 32'h0);
    nxt();
    chk("c1_valid", valid, 0);
    chk("c1_addr", addr, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      nxt();
      chk("stream_valid", valid, 1);
      chk("stream_added", added_pc, 32'(4 * k));
      chk("stream_inst", inst, inst_of(32'(4 * (k - 1))));
      chk("stream_addr", addr, 32'(4 * k));
      if (k < 3) begin
        nxt();
        chk("stream_gap", valid, 0);
      end
    end

    // hazard stall for 6 cycles: fills 2 entries, issue stops, head held
    stall_i = 1'b1;
    nxt();
    nxt();
    chk("full_req", req, 0);
    chk("full_added", added_pc, 32'd12);
    chk("full_inst", inst, inst_of(32'd8));
    nxt(); nxt(); nxt();
    chk("hold_req", req, 0);
    chk("hold_added", added_pc, 32'd12);
    nxt();
    stall_i = 1'b0;
    nxt();
    chk("drain_added", added_pc, 32'd16);
    chk("drain_inst", inst, inst_of(32'd12));
    chk("drain_addr", addr, 32'd16);
    nxt();
    chk("drain_empty", valid, 0);

    // 3-cycle memory, branch to 0x40 while REQ at 0x8
    rst_i = 1'b1;
    mem_lat = 3;
    nxt();
    rst_i = 1'b0;
    repeat (9) nxt();
    chk("lat3_req", req, 1);
    chk("lat3_addr", addr, 32'h8);
    brench_i = 1'b1; brench_target_i = 32'h40;
    nxt();
    brench_i = 1'b0;
    chk("drop_req", req, 1);
    chk("drop_addr", addr, 32'h8);
    chk("drop_valid", valid, 0);
    nxt();
    chk("drop_addr2", addr, 32'h8);
    nxt();
    chk("redir_addr", addr, 32'h40);
    chk("redir_valid", valid, 0);
    repeat (4) nxt();
    chk("tgt_valid", valid, 1);
    chk("tgt_added", added_pc, 32'h44);
    chk("tgt_inst", inst, inst_of(32'h40));

    // branch and jump together: branch wins, FIFO flushed
    brench_i = 1'b1; brench_target_i = 32'h100;
    jump_i = 1'b1; jump_target_i = 32'h200;
    nxt();
    brench_i = 1'b0; jump_i = 1'b0;
    chk("bj_empty", valid, 0);
    chk("bj_stale", addr, 32'h44);
    repeat (3) nxt();
    chk("bj_req", req, 1);
    chk("bj_addr", addr, 32'h100);
    mem_lat = 1;

    // redirect coincident with ack and pop, unaligned target
    nxt();
    nxt();
    chk("co_added", added_pc, 32'h104);
    chk("co_inst", inst, inst_of(32'h100));
    stall_i = 1'b1;
    nxt();
    chk("co_valid", valid, 1);
    chk("co_acked", addr, 32'h104);
    stall_i = 1'b0;
    brench_i = 1'b1; brench_target_i = 32'h23;
    nxt();
    brench_i = 1'b0;
    chk("co_flush", valid, 0);
    chk("co_addr", addr, 32'h20);
    nxt();
    nxt();
    chk("co_after", added_pc, 32'h24);
    chk("co_inst2", inst, inst_of(32'h20));

    // PC wrap from 0xFFFF_FFFC and async reset mid-request
    rst2_i = 1'b0;
    #1;
    chk("hi_first", addr2, 32'hFFFF_FFFC);
    nxt();
    nxt();
    chk("hi_valid", valid2, 1);
    chk("hi_added", added_pc2, 32'h0);
    chk("hi_inst", inst2, inst_of(32'hFFFF_FFFC));
    chk("hi_next", addr2, 32'h0);
    nxt();
    chk("hi_req", req2, 1);
    rst2_i = 1'b1;
    #1;
    chk("hi_rst_req", req2, 0);
    chk("hi_rst_valid", valid2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
